core_io_responder: RTL and testbench
====================================

// Module: core_io_responder
// PURPOSE
//  Peripheral-side responder for the core's to_peripheral/from_peripheral port pair.
//  Decodes core I/O commands, buffers core->host words in an OUT FIFO and
//  host->core words in an IN FIFO, and returns a 1-cycle-latency response to the core.
//  Sits between RISC_V_Core and the host/bench-side stream interface.
// PARAMETERS
//  DATA_WIDTH  32   width of to_/from_peripheral_data and FIFO entries
//  FIFO_DEPTH  8    entries per FIFO; power of 2, 2..128
//  CNT_BITS    $clog2(FIFO_DEPTH)+1   occupancy counter width (<=8)
// PORTS
//  clock                  in   1           single clock, rising edge
//  reset                  in   1           asynchronous, active-high
//  to_peripheral          in   2           core command code (valid-qualified)
//  to_peripheral_data     in   DATA_WIDTH  command payload
//  to_peripheral_valid    in   1           command strobe, one command per cycle
//  from_peripheral        out  2           response code
//  from_peripheral_data   out  DATA_WIDTH  response payload
//  from_peripheral_valid  out  1           response strobe (1-cycle pulse)
//  host_in_data           in   DATA_WIDTH  host->core word
//  host_in_valid          in   1           host push request
//  host_in_ready          out  1           = !in_full
//  host_out_data          out  DATA_WIDTH  OUT FIFO head
//  host_out_valid         out  1           = !out_empty
//  host_out_ready         in   1           host pop
// BEHAVIOUR
//  Reset (async): both FIFOs empty, pointers/counts 0, sticky flags 0,
//   from_peripheral=2'b00, from_peripheral_data=0, from_peripheral_valid=0,
//   host_in_ready=1, host_out_valid=0, host_out_data=0. Reset mid-transfer discards all.
//  Commands (sampled when to_peripheral_valid=1):
//   2'b00 NOP    : no response.
//   2'b01 PUT    : push data into OUT FIFO; response code 2'b01, data 0.
//                  If full (after same-cycle host pop credit): drop, set OUT_OVF sticky.
//   2'b10 GET    : pop IN FIFO; response code 2'b10, data=head word.
//                  If empty: response code 2'b11, data 0, set GET_UNF sticky; no bypass
//                  of a same-cycle host push.
//   2'b11 STATUS : response code 2'b11 w/ data = {OUT_OVF,GET_UNF,14'b0,in_count[7:0],out_count[7:0]};
//                  counts zero-extended, value before this cycle's updates.
//                  Clears both stickies; a same-cycle new set event wins over clear.
//  Response registered: valid exactly 1 cycle after command cycle; back-to-back
//   commands yield back-to-back responses; valid drops when no command issued.
//  FIFO rules: simultaneous push+pop allowed at any occupancy except push-on-full
//   without pop (OUT: rejected, IN: prevented by ready) and pop-on-empty (no-op).
//   Pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
//  host_out_data = OUT FIFO head (combinational from storage, 0 when empty).
// CONFIGURATION
//  IO_RESPONDER_TIMESTAMP_EN defined: free-running 32-bit cycle counter (reset 0,
//   wraps); STATUS with to_peripheral_data[0]=1 returns the counter instead of the
//   status word and does NOT clear stickies. Not defined: counter absent,
//   to_peripheral_data ignored for STATUS.
// STRUCTURE
//  Shared package io_peripheral_pkg: command codes (IO_NOP/IO_PUT/IO_GET/IO_STATUS),
//   response codes, status-word bit positions.
//  Sub-module io_sync_fifo (DATA_WIDTH, FIFO_DEPTH): push/pop/full/empty/count/head;
//   instantiated twice (OUT, IN). Command decode + response register in top.
// TESTING
//  1 Reset, then idle 10 cycles -> all outputs at reset values, host_in_ready=1.
//  2 PUT 0xDEADBEEF, PUT 0x1 -> two responses 2'b01 on cycles N+1,N+2;
//    host_out_data=0xDEADBEEF then 0x1 on host pops; host_out_valid=0 after.
//  3 Host pushes 0x1000,0x80000000; GET,GET,GET -> 2'b10/0x1000, 2'b10/0x80000000,
//    2'b11/0; next STATUS -> data 0x40000000; following STATUS -> 0x00000000.
//  4 FIFO_DEPTH=8: 9 PUTs, host_out_ready=0 -> STATUS data 0x80000008; 9th word lost.
//  5 OUT full, PUT with host_out_ready=1 same cycle -> accepted, out_count stays 8,
//    OUT_OVF stays 0; IN full -> host_in_ready=0.
//  6 Assert reset with 3 words in each FIFO and a response pending -> outputs reset
//    immediately (async); STATUS after release -> 0x00000000. TIMESTAMP_EN build:
//    STATUS data[0]=1 at consecutive cycles -> values differ by 1.

Source files
------------

// File: rtl/io_peripheral_pkg.sv
// Shared definitions for the core I/O responder: command/response codes and
// status-word layout.
package io_peripheral_pkg;

  typedef enum logic [1:0] {
    IO_NOP    = 2'b00,
    IO_PUT    = 2'b01,
    IO_GET    = 2'b10,
    IO_STATUS = 2'b11
  } io_cmd_e;

  // 2'b11 doubles as the STATUS reply and the GET-underflow reply.
  typedef enum logic [1:0] {
    RSP_NONE     = 2'b00,
    RSP_PUT_ACK  = 2'b01,
    RSP_GET_DATA = 2'b10,
    RSP_STAT_ERR = 2'b11
  } io_rsp_e;

  localparam int unsigned STAT_OUT_OVF_BIT = 31;
  localparam int unsigned STAT_GET_UNF_BIT = 30;
  localparam int unsigned STAT_IN_CNT_LSB  = 8;
  localparam int unsigned STAT_OUT_CNT_LSB = 0;

  function automatic logic [31:0] pack_status(input logic       out_ovf,
                                              input logic       get_unf,
                                              input logic [7:0] in_cnt,
                                              input logic [7:0] out_cnt);
    logic [31:0] s;
    s                            = '0;
    s[STAT_OUT_OVF_BIT]          = out_ovf;
    s[STAT_GET_UNF_BIT]          = get_unf;
    s[STAT_IN_CNT_LSB +: 8]      = in_cnt;
    s[STAT_OUT_CNT_LSB +: 8]     = out_cnt;
    return s;
  endfunction

endpackage

// File: rtl/core_io_responder_if.sv
// Core command/response port pair plus host-side IN/OUT streams.
interface core_io_responder_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [1:0]            to_peripheral;
  logic [DATA_WIDTH-1:0] to_peripheral_data;
  logic                  to_peripheral_valid;
  logic [1:0]            from_peripheral;
  logic [DATA_WIDTH-1:0] from_peripheral_data;
  logic                  from_peripheral_valid;
  logic [DATA_WIDTH-1:0] host_in_data;
  logic                  host_in_valid;
  logic                  host_in_ready;
  logic [DATA_WIDTH-1:0] host_out_data;
  logic                  host_out_valid;
  logic                  host_out_ready;

  modport master (
    output to_peripheral, to_peripheral_data, to_peripheral_valid,
           host_in_data, host_in_valid, host_out_ready,
    input  from_peripheral, from_peripheral_data, from_peripheral_valid,
           host_in_ready, host_out_data, host_out_valid
  );

  modport slave (
    input  to_peripheral, to_peripheral_data, to_peripheral_valid,
           host_in_data, host_in_valid, host_out_ready,
    output from_peripheral, from_peripheral_data, from_peripheral_valid,
           host_in_ready, host_out_data, host_out_valid
  );
endinterface

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with push/pop in the same cycle; head is 0 when empty.
module io_sync_fifo #(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned FIFO_DEPTH = 8,
  localparam int unsigned PTR_BITS   = $clog2(FIFO_DEPTH),
  localparam int unsigned CNT_BITS   = PTR_BITS + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [CNT_BITS-1:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_BITS-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign full_o  = (cnt_q == CNT_BITS'(FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

  // A pop in the same cycle frees the slot a push on full needs.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PTR_BITS'(1);
    if (do_pop)  rd_d = rd_q + PTR_BITS'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_BITS'(1);
      2'b01:   cnt_d = cnt_q - CNT_BITS'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/core_io_responder.sv
// Core I/O responder: decodes core commands, buffers OUT/IN streams, registers
// a one-cycle-latency response. Optional cycle counter: IO_RESPONDER_TIMESTAMP_EN.
module core_io_responder
  import io_peripheral_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_BITS   = $clog2(FIFO_DEPTH) + 1
) (
  input logic                 clock,
  input logic                 reset,
  core_io_responder_if.slave  bus
);
  io_cmd_e               cmd;
  logic                  put_c, get_c, stat_c, clr_c;
  logic                  out_full, out_empty, out_pop;
  logic                  in_full, in_empty, in_push;
  logic [CNT_BITS-1:0]   out_cnt, in_cnt;
  logic [DATA_WIDTH-1:0] out_head, in_head, status_w;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  rsp_valid_q, rsp_valid_d;
  io_rsp_e               rsp_code_q, rsp_code_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  assign cmd    = io_cmd_e'(bus.to_peripheral);
  assign put_c  = bus.to_peripheral_valid && (cmd == IO_PUT);
  assign get_c  = bus.to_peripheral_valid && (cmd == IO_GET);
  assign stat_c = bus.to_peripheral_valid && (cmd == IO_STATUS);

  assign out_pop = bus.host_out_ready && !out_empty;
  assign in_push = bus.host_in_valid && !in_full;

  io_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk_i(clock), .rst_i(reset), .push_i(put_c), .pop_i(out_pop),
    .data_i(bus.to_peripheral_data), .head_o(out_head), .count_o(out_cnt),
    .full_o(out_full), .empty_o(out_empty)
  );

  io_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk_i(clock), .rst_i(reset), .push_i(in_push), .pop_i(get_c),
    .data_i(bus.host_in_data), .head_o(in_head), .count_o(in_cnt),
    .full_o(in_full), .empty_o(in_empty)
  );

  assign bus.host_in_ready         = !in_full;
  assign bus.host_out_valid        = !out_empty;
  assign bus.host_out_data         = out_head;
  assign bus.from_peripheral       = rsp_code_q;
  assign bus.from_peripheral_data  = rsp_data_q;
  assign bus.from_peripheral_valid = rsp_valid_q;

  assign status_w = DATA_WIDTH'(pack_status(ovf_q, unf_q, 8'(in_cnt), 8'(out_cnt)));

`ifdef IO_RESPONDER_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic        ts_sel;
  assign ts_sel = bus.to_peripheral_data[0];
  assign clr_c  = stat_c && !ts_sel;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + 32'd1;
  end
`else
  assign clr_c = stat_c;
`endif

  always_comb begin
    // Set events take priority over a STATUS clear in the same cycle.
    ovf_d       = (put_c && out_full && !out_pop) || (ovf_q && !clr_c);
    unf_d       = (get_c && in_empty) || (unf_q && !clr_c);
    rsp_valid_d = bus.to_peripheral_valid && (cmd != IO_NOP);
    rsp_code_d  = RSP_NONE;
    rsp_data_d  = '0;
    if (put_c) begin
      rsp_code_d = RSP_PUT_ACK;
    end else if (get_c) begin
      rsp_code_d = in_empty ? RSP_STAT_ERR : RSP_GET_DATA;
      rsp_data_d = in_head;
    end else if (stat_c) begin
      rsp_code_d = RSP_STAT_ERR;
`ifdef IO_RESPONDER_TIMESTAMP_EN
      rsp_data_d = ts_sel ? DATA_WIDTH'(ts_q) : status_w;
`else
      rsp_data_d = status_w;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_code_q  <= RSP_NONE;
      rsp_data_q  <= '0;
    end else begin
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_code_q  <= rsp_code_d;
      rsp_data_q  <= rsp_data_d;
    end
  end
endmodule

// File: tb/tb_core_io_responder.sv
// Self-checking bench for core_io_responder: vector table plus response scoreboard.
module tb_core_io_responder;
  localparam logic [1:0] C_NOP = 2'b00, C_PUT = 2'b01, C_GET = 2'b10, C_STAT = 2'b11;

  typedef struct {
    logic        cv;
    logic [1:0]  cmd;
    logic [31:0] d;
    logic        hiv;
    logic [31:0] hid;
    logic        hor;
    logic [1:0]  ecode;
    logic [31:0] edata;
    logic        ehov;
    logic [31:0] ehod;
  } vec_t;

  typedef struct {
    logic [1:0]  code;
    logic [31:0] data;
  } rsp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];
  vec_t vt[15];

  core_io_responder_if #(.DATA_WIDTH(32)) bus ();

  core_io_responder #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic cv, input logic [1:0] cmd, input logic [31:0] d,
                        input logic hiv, input logic [31:0] hid, input logic hor);
    bus.to_peripheral_valid = cv;
    bus.to_peripheral       = cmd;
    bus.to_peripheral_data  = d;
    bus.host_in_valid       = hiv;
    bus.host_in_data        = hid;
    bus.host_out_ready      = hor;
  endtask

  // One clock: drive, predict, then compare the response against the scoreboard.
  task automatic cyc(input logic cv, input logic [1:0] cmd, input logic [31:0] d,
                     input logic hiv, input logic [31:0] hid, input logic hor,
                     input logic [1:0] ecode, input logic [31:0] edata);
    rsp_t e;
    if (cv && cmd != C_NOP) exp_q.push_back('{code: ecode, data: edata});
    set_in(cv, cmd, d, hiv, hid, hor);
    @(posedge clock);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rsp_valid", 32'(bus.from_peripheral_valid), 32'd1);
      chk("rsp_code", 32'(bus.from_peripheral), 32'(e.code));
      chk("rsp_data", bus.from_peripheral_data, e.data);
    end else begin
      chk("rsp_idle_valid", 32'(bus.from_peripheral_valid), 32'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, C_NOP, '0, 1'b0, '0, 1'b0, 2'b00, '0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus.from_peripheral_valid), 32'd0);
    chk({tag, "_code"}, 32'(bus.from_peripheral), 32'd0);
    chk({tag, "_data"}, bus.from_peripheral_data, 32'd0);
    chk({tag, "_hir"}, 32'(bus.host_in_ready), 32'd1);
    chk({tag, "_hov"}, 32'(bus.host_out_valid), 32'd0);
    chk({tag, "_hod"}, bus.host_out_data, 32'd0);
  endtask

  function automatic vec_t mk(input logic cv, input logic [1:0] cmd, input logic [31:0] d,
                              input logic hiv, input logic [31:0] hid, input logic hor,
                              input logic [1:0] ec, input logic [31:0] ed,
                              input logic hov, input logic [31:0] hod);
    vec_t v;
    v.cv = cv; v.cmd = cmd; v.d = d; v.hiv = hiv; v.hid = hid; v.hor = hor;
    v.ecode = ec; v.edata = ed; v.ehov = hov; v.ehod = hod;
    return v;
  endfunction

  initial begin
    vt[0]  = mk(1, C_PUT,  32'hDEADBEEF, 0, 0,            0, 2'b01, 0,            1, 32'hDEADBEEF);
    vt[1]  = mk(1, C_PUT,  32'h1,        0, 0,            0, 2'b01, 0,            1, 32'hDEADBEEF);
    vt[2]  = mk(0, C_NOP,  0,            0, 0,            1, 2'b00, 0,            1, 32'h1);
    vt[3]  = mk(0, C_NOP,  0,            0, 0,            1, 2'b00, 0,            0, 0);
    vt[4]  = mk(0, C_NOP,  0,            1, 32'h1000,     0, 2'b00, 0,            0, 0);
    vt[5]  = mk(0, C_NOP,  0,            1, 32'h80000000, 0, 2'b00, 0,            0, 0);
    vt[6]  = mk(1, C_GET,  0,            0, 0,            0, 2'b10, 32'h1000,     0, 0);
    vt[7]  = mk(1, C_GET,  0,            0, 0,            0, 2'b10, 32'h80000000, 0, 0);
    vt[8]  = mk(1, C_GET,  0,            0, 0,            0, 2'b11, 0,            0, 0);
    vt[9]  = mk(1, C_STAT, 0,            0, 0,            0, 2'b11, 32'h40000000, 0, 0);
    vt[10] = mk(1, C_STAT, 0,            0, 0,            0, 2'b11, 32'h00000000, 0, 0);
    vt[11] = mk(1, C_GET,  0,            1, 32'h55,       0, 2'b11, 0,            0, 0);
    vt[12] = mk(1, C_STAT, 0,            0, 0,            0, 2'b11, 32'h40000100, 0, 0);
    vt[13] = mk(1, C_GET,  0,            0, 0,            0, 2'b10, 32'h55,       0, 0);
    vt[14] = mk(1, C_STAT, 0,            0, 0,            0, 2'b11, 32'h00000000, 0, 0);

    set_in(1'b0, C_NOP, '0, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    chk_reset_outputs("in_reset");
    reset = 1'b0;
    idle(10);
    chk_reset_outputs("after_idle");

    for (int i = 0; i < 15; i++) begin
      cyc(vt[i].cv, vt[i].cmd, vt[i].d, vt[i].hiv, vt[i].hid, vt[i].hor, vt[i].ecode, vt[i].edata);
      chk($sformatf("vec%0d_hov", i), 32'(bus.host_out_valid), 32'(vt[i].ehov));
      chk($sformatf("vec%0d_hod", i), bus.host_out_data, vt[i].ehod);
      chk($sformatf("vec%0d_hir", i), 32'(bus.host_in_ready), 32'd1);
    end

    // OUT overflow: ninth word is dropped and flagged.
    for (int i = 0; i < 9; i++) cyc(1, C_PUT, 32'h100 + 32'(i), 0, 0, 0, 2'b01, 0);
    chk("ovf_head", bus.host_out_data, 32'h100);
    cyc(1, C_STAT, 0, 0, 0, 0, 2'b11, 32'h80000008);

    // PUT on full with a same-cycle host pop is accepted.
    cyc(1, C_PUT, 32'hAA, 0, 0, 1, 2'b01, 0);
    chk("credit_head", bus.host_out_data, 32'h101);
    cyc(1, C_STAT, 0, 0, 0, 0, 2'b11, 32'h00000008);

    for (int k = 0; k < 8; k++) begin
      cyc(0, C_NOP, 0, 1, 32'h200 + 32'(k), 0, 2'b00, 0);
      chk($sformatf("in_fill%0d_hir", k), 32'(bus.host_in_ready), (k < 7) ? 32'd1 : 32'd0);
    end
    cyc(0, C_NOP, 0, 1, 32'h2FF, 0, 2'b00, 0);
    cyc(1, C_STAT, 0, 0, 0, 0, 2'b11, 32'h00000808);

    for (int j = 0; j < 8; j++) begin
      cyc(0, C_NOP, 0, 0, 0, 1, 2'b00, 0);
      chk($sformatf("drain%0d_hod", j), bus.host_out_data,
          (j < 6) ? 32'h102 + 32'(j) : ((j == 6) ? 32'hAA : 32'h0));
      chk($sformatf("drain%0d_hov", j), 32'(bus.host_out_valid), (j < 7) ? 32'd1 : 32'd0);
    end

    for (int k = 0; k < 5; k++) cyc(1, C_GET, 0, 0, 0, 0, 2'b10, 32'h200 + 32'(k));
    for (int k = 0; k < 3; k++) cyc(1, C_PUT, 32'h300 + 32'(k), 0, 0, 0, 2'b01, 0);
    cyc(1, C_STAT, 0, 0, 0, 0, 2'b11, 32'h00000303);

    // Asynchronous reset while a response is being presented.
    #2;
    set_in(1'b0, C_NOP, '0, 1'b0, '0, 1'b0);
    reset = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(1);
    cyc(1, C_STAT, 0, 0, 0, 0, 2'b11, 32'h00000000);
    chk("post_reset_hov", 32'(bus.host_out_valid), 32'd0);

`ifdef IO_RESPONDER_TIMESTAMP_EN
    begin
      logic [31:0] t0, t1;
      set_in(1'b1, C_STAT, 32'h1, 1'b0, '0, 1'b0);
      @(posedge clock);
      #1;
      t0 = bus.from_peripheral_data;
      @(posedge clock);
      #1;
      t1 = bus.from_peripheral_data;
      chk("ts_valid", 32'(bus.from_peripheral_valid), 32'd1);
      chk("ts_delta", t1 - t0, 32'd1);
      set_in(1'b0, C_NOP, '0, 1'b0, '0, 1'b0);
      @(posedge clock);
      #1;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
